dram_refresh_arbiter: RTL
=========================

// Module: dram_refresh_arbiter
// PURPOSE
// - Sequences the on-board 8MB FastRAM DRAM: arbitrates 68000 bus accesses against CAS-before-RAS refresh.
// - Periodic interval timer accrues refresh debt; refreshes are issued only in bus-idle gaps (no DTACK stall available).
// - Drives RASn/UCASn/LCASn and the row/column mux select; enforces RAS precharge between every DRAM cycle.
// - Sits between the address decode/autoconfig match logic (RAM_SEL) and the DRAM pins.
// PARAMETERS
// - REFRESH_INTERVAL  110  CLK cycles per owed refresh (15.5us at 7.09MHz)
// - MAX_DEBT          8    saturation limit of owed refreshes
// - T_RP              1    RAS precharge cycles after any RAS deassertion
// - T_RAS_REF         2    cycles RAS held during a refresh
// PORTS
// - CLK           in   1  7MHz bus clock; all logic on rising edge
// - RESET         in   1  synchronous, active-high reset
// - ASn           in   1  68000 address strobe, active low
// - UDSn          in   1  upper data strobe, active low
// - LDSn          in   1  lower data strobe, active low
// - RAM_SEL       in   1  decoded hit: address in a configured FastRAM block
// - RASn          out  1  DRAM row strobe, active low
// - UCASn         out  1  DRAM upper column strobe, active low
// - LCASn         out  1  DRAM lower column strobe, active low
// - MUX_COL       out  1  1 = present column address, 0 = row address
// - REF_DEBT      out  $clog2(MAX_DEBT+1)  owed refresh count
// - REF_OVERFLOW  out  1  sticky: interval tick arrived with debt already at MAX_DEBT
// BEHAVIOUR
// - Reset: state IDLE, RASn/UCASn/LCASn=1, MUX_COL=0, interval counter=0, REF_DEBT=0, REF_OVERFLOW=0; takes effect next edge even mid-cycle.
// - All outputs registered; one-cycle latency from sampled inputs.
// - Interval counter counts 0..REFRESH_INTERVAL-1, wraps to 0; tick on wrap.
// - Debt: +1 on tick, -1 when REF_RAS entered; both same cycle -> unchanged. Tick at MAX_DEBT -> hold, set REF_OVERFLOW.
// - States: IDLE, ACC_RAS, ACC_CAS, REF_CAS, REF_RAS, PRECH.
// - IDLE: RAM_SEL & !ASn -> ACC_RAS (priority over refresh); else ASn & REF_DEBT!=0 -> REF_CAS.
// - ACC_RAS: RASn=0, MUX_COL=0 first cycle, MUX_COL=1 from next cycle; !UDSn|!LDSn -> ACC_CAS.
// - ACC_CAS: RASn=0, UCASn=UDSn, LCASn=LDSn (registered), MUX_COL=1; hold until ASn=1 -> PRECH.
// - ASn rising in ACC_RAS (aborted cycle) -> PRECH, no CAS.
// - REF_CAS: UCASn=LCASn=0, RASn=1, one cycle -> REF_RAS.
// - REF_RAS: RASn=0, CASn=0 for T_RAS_REF cycles -> PRECH.
// - PRECH: all strobes high, MUX_COL=0 for T_RP cycles -> IDLE.
// - Access request arriving during REF_* or PRECH waits; sampled on return to IDLE (68000 wait-free timing holds at 7MHz since refresh + precharge <= 4 cycles).
// - Never issue RAS while any CAS of an access is pending; never two refreshes back to back without PRECH.
// STRUCTURE
// - Shared pkg gottagofast_pkg: state enum (dram_state_t), default timing constants.
// - Sub-module refresh_timer: interval counter + debt counter + overflow flag; arbiter FSM in top.
// TESTING
// - Reset then idle bus (ASn=1) 1000 cycles -> exactly 9 refreshes, first REF_CAS at cycle 111, REF_DEBT never >1.
// - Word read RAM_SEL=1, ASn=0, UDSn=LDSn=0 one cycle later -> RASn low next edge, MUX_COL=1 one cycle later, both CAS low, release 1 cycle after ASn high, RASn high for T_RP.
// - Byte write LDSn=0, UDSn=1 -> only LCASn asserted, UCASn stays 1 whole cycle.
// - Tick coincides with RAM_SEL&!ASn in IDLE -> access wins, REF_DEBT=1, refresh issued immediately after PRECH once ASn=1.
// - Hold ASn=0 on non-RAM address for 9*110 cycles -> REF_DEBT saturates at 8, REF_OVERFLOW=1; release -> 8 back-to-back refresh+PRECH sequences, debt 0.
// - Assert RESET during REF_RAS -> next edge all strobes high, REF_DEBT=0, state IDLE.

Source files
------------

// File: rtl/gottagofast_pkg.sv
// rtl/gottagofast_pkg.sv - FastRAM DRAM sequencer states, strobe bundle and default timing
package gottagofast_pkg;

    localparam int DEF_REFRESH_INTERVAL = 110;
    localparam int DEF_MAX_DEBT         = 8;
    localparam int DEF_T_RP             = 1;
    localparam int DEF_T_RAS_REF        = 2;

    typedef enum logic [2:0] {
        IDLE,
        ACC_RAS,
        ACC_CAS,
        REF_CAS,
        REF_RAS,
        PRECH
    } dram_state_t;

    typedef struct packed {
        logic ras_n;
        logic ucas_n;
        logic lcas_n;
        logic mux_col;
    } dram_strobes_t;

    localparam dram_strobes_t STROBES_IDLE = '{ras_n: 1'b1, ucas_n: 1'b1, lcas_n: 1'b1, mux_col: 1'b0};

endpackage

// File: rtl/dram_refresh_arbiter_if.sv
// rtl/dram_refresh_arbiter_if.sv - 68000 bus side and DRAM strobe side of the FastRAM sequencer
interface dram_refresh_arbiter_if;

    logic ASn;
    logic UDSn;
    logic LDSn;
    logic RAM_SEL;
    logic RASn;
    logic UCASn;
    logic LCASn;
    logic MUX_COL;

    modport master (
        output ASn, UDSn, LDSn, RAM_SEL,
        input  RASn, UCASn, LCASn, MUX_COL
    );

    modport slave (
        input  ASn, UDSn, LDSn, RAM_SEL,
        output RASn, UCASn, LCASn, MUX_COL
    );

endinterface

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - refresh interval timer, saturating owed-refresh counter, sticky overflow
module refresh_timer
    import gottagofast_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_DEBT         = DEF_MAX_DEBT
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ref_dec,
    output logic [$clog2(MAX_DEBT+1)-1:0] debt,
    output logic                          overflow
);

    localparam int IW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int DW = $clog2(MAX_DEBT + 1);

    logic [IW-1:0] interval_q;
    logic          tick;
    logic          debt_full;

    assign tick      = (interval_q == IW'(REFRESH_INTERVAL - 1));
    assign debt_full = (debt == DW'(MAX_DEBT));

    // A tick and a consumed refresh in the same cycle cancel out.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            interval_q <= '0;
            debt       <= '0;
            overflow   <= 1'b0;
        end else begin
            interval_q <= tick ? '0 : interval_q + IW'(1);
            if (tick && debt_full) begin
                overflow <= 1'b1;
            end
            if (tick && !ref_dec && !debt_full) begin
                debt <= debt + DW'(1);
            end else if (ref_dec && !tick && (debt != '0)) begin
                debt <= debt - DW'(1);
            end
        end
    end

endmodule

// File: rtl/dram_refresh_arbiter.sv
// rtl/dram_refresh_arbiter.sv - FastRAM DRAM sequencer: 68000 accesses vs CAS-before-RAS refresh
module dram_refresh_arbiter
    import gottagofast_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_DEBT         = DEF_MAX_DEBT,
    parameter int T_RP             = DEF_T_RP,
    parameter int T_RAS_REF        = DEF_T_RAS_REF
) (
    input  logic                          CLK,
    input  logic                          RESET,
    dram_refresh_arbiter_if.slave         bus,
    output logic [$clog2(MAX_DEBT+1)-1:0] REF_DEBT,
    output logic                          REF_OVERFLOW
);

    localparam int CNT_MAX = (T_RAS_REF > T_RP) ? T_RAS_REF : T_RP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    dram_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dram_strobes_t    str_q, str_d;
    logic             ref_dec;

    refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_DEBT         (MAX_DEBT)
    ) u_refresh_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .ref_dec  (ref_dec),
        .debt     (REF_DEBT),
        .overflow (REF_OVERFLOW)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            str_q   <= STROBES_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        str_d   = STROBES_IDLE;
        ref_dec = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.RAM_SEL && !bus.ASn) begin
                    state_d = ACC_RAS;
                end else if (bus.ASn && (REF_DEBT != '0)) begin
                    state_d = REF_CAS;
                end
            end
            ACC_RAS: begin
                if (bus.ASn) begin
                    state_d = PRECH;
                end else if (!bus.UDSn || !bus.LDSn) begin
                    state_d = ACC_CAS;
                end
            end
            ACC_CAS: begin
                if (bus.ASn) begin
                    state_d = PRECH;
                end
            end
            REF_CAS: begin
                state_d = REF_RAS;
                ref_dec = 1'b1;
            end
            REF_RAS: begin
                if (cnt_q == CNT_W'(T_RAS_REF - 1)) begin
                    state_d = PRECH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRECH: begin
                if (cnt_q == CNT_W'(T_RP - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the state being entered, so pins follow the state edge.
        case (state_d)
            ACC_RAS: str_d = '{ras_n: 1'b0, ucas_n: 1'b1, lcas_n: 1'b1, mux_col: (state_q == ACC_RAS)};
            ACC_CAS: str_d = '{ras_n: 1'b0, ucas_n: bus.UDSn, lcas_n: bus.LDSn, mux_col: 1'b1};
            REF_CAS: str_d = '{ras_n: 1'b1, ucas_n: 1'b0, lcas_n: 1'b0, mux_col: 1'b0};
            REF_RAS: str_d = '{ras_n: 1'b0, ucas_n: 1'b0, lcas_n: 1'b0, mux_col: 1'b0};
            default: str_d = STROBES_IDLE;
        endcase
    end

    assign bus.RASn    = str_q.ras_n;
    assign bus.UCASn   = str_q.ucas_n;
    assign bus.LCASn   = str_q.lcas_n;
    assign bus.MUX_COL = str_q.mux_col;

endmodule
